// File: rtl/sram_1p_march_bist.sv
// Purpose: single-port SRAM behavioural model with per-bit write mask and a built-in March C- self-test.
// Latency: 1-cycle registered read (read-first on a same-cycle write); self-test busy for 10*DEPTH+1 cycles.
// Backpressure: none; while A_BIST_BUSY the functional port is ignored. Self-test is compiled in by SRAM_MARCH_BIST_EN.
module sram_1p_march_bist #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  A_CLK,
  input  logic                  A_RST,
  input  logic                  A_MEN,
  input  logic                  A_WEN,
  input  logic                  A_REN,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic [DATA_WIDTH-1:0] A_DIN,
  input  logic [DATA_WIDTH-1:0] A_BM,
  output logic [DATA_WIDTH-1:0] A_DOUT,
  input  logic                  A_BIST_START,
  output logic                  A_BIST_BUSY,
  output logic                  A_BIST_DONE,
  output logic                  A_BIST_FAIL,
  output logic [ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Array is deliberately not reset: contents are undefined after power-up or reset.
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  // Array access after the functional / self-test mux.
  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_bm;

`ifdef SRAM_MARCH_BIST_EN
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_M0    = 4'd1;
  localparam logic [3:0] ST_M1    = 4'd2;
  localparam logic [3:0] ST_M2    = 4'd3;
  localparam logic [3:0] ST_M3    = 4'd4;
  localparam logic [3:0] ST_M4    = 4'd5;
  localparam logic [3:0] ST_M5    = 4'd6;
  localparam logic [3:0] ST_DRAIN = 4'd7;
  localparam logic [3:0] ST_DONE  = 4'd8;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  logic [3:0]            state;
  logic [3:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ph;          // 0 = read step, 1 = write step of a two-op element
  logic                  busy;
  logic                  el_two;
  logic                  el_down;
  logic                  nxt_down;
  logic                  rd_one;
  logic                  wr_one;
  logic                  b_rd;
  logic                  b_wr;
  logic                  last_addr;
  logic                  el_end;
  logic                  cmp_vld;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;

  // Decode the current March element: direction, operations and backgrounds.
  always_comb begin
    busy      = (state != ST_IDLE) && (state != ST_DONE);
    el_two    = (state == ST_M1) || (state == ST_M2) || (state == ST_M3) || (state == ST_M4);
    el_down   = (state == ST_M3) || (state == ST_M4);
    rd_one    = (state == ST_M2) || (state == ST_M4);
    wr_one    = (state == ST_M1) || (state == ST_M3);
    b_rd      = (el_two && !ph) || (state == ST_M5);
    b_wr      = (el_two && ph) || (state == ST_M0);
    last_addr = el_down ? (addr == '0) : (addr == ADDR_MAX);
    el_end    = busy && (state != ST_DRAIN) && last_addr && (!el_two || ph);
  end

  // Next-state: elements run back to back; START only honoured when not busy.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (A_BIST_START) state_nxt = ST_M0;
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: if (el_end) state_nxt = state + 4'd1;
      ST_DRAIN: state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
    nxt_down = (state_nxt == ST_M3) || (state_nxt == ST_M4);
  end

  // Sequencer, address walk, and compare of the previous cycle's read data.
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      state     <= ST_IDLE;
      addr      <= '0;
      ph        <= 1'b0;
      cmp_vld   <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
    end else begin
      state    <= state_nxt;
      cmp_vld  <= b_rd;
      cmp_exp  <= {DATA_WIDTH{rd_one}};
      cmp_addr <= addr;
      if (busy && (state != ST_DRAIN)) begin
        if (el_two) ph <= ~ph;
        if (el_end) addr <= nxt_down ? ADDR_MAX : '0;
        else if (!el_two || ph) addr <= el_down ? addr - 1'b1 : addr + 1'b1;
      end
      // Only the first mismatch is recorded.
      if (cmp_vld && (A_DOUT != cmp_exp) && !fail) begin
        fail      <= 1'b1;
        fail_addr <= cmp_addr;
      end
      if (!busy && A_BIST_START) begin
        addr      <= '0;
        ph        <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
      end
    end
  end

  // Self-test owns the array while busy, with full-word writes.
  always_comb begin
    mem_we   = busy ? b_wr : (A_MEN && A_WEN);
    mem_re   = busy ? b_rd : (A_MEN && A_REN);
    mem_addr = busy ? addr : A_ADDR;
    mem_din  = busy ? {DATA_WIDTH{wr_one}} : A_DIN;
    mem_bm   = busy ? {DATA_WIDTH{1'b1}} : A_BM;
  end

  assign A_BIST_BUSY      = busy;
  assign A_BIST_DONE      = (state == ST_DONE);
  assign A_BIST_FAIL      = fail;
  assign A_BIST_FAIL_ADDR = fail_addr;
`else
  logic unused_bist_start;
  assign unused_bist_start = A_BIST_START;

  // Functional port drives the array directly.
  always_comb begin
    mem_we   = A_MEN && A_WEN;
    mem_re   = A_MEN && A_REN;
    mem_addr = A_ADDR;
    mem_din  = A_DIN;
    mem_bm   = A_BM;
  end

  assign A_BIST_BUSY      = 1'b0;
  assign A_BIST_DONE      = 1'b0;
  assign A_BIST_FAIL      = 1'b0;
  assign A_BIST_FAIL_ADDR = '0;
`endif

  // Masked write: only bits with mask 1 take the new data.
  always_ff @(posedge A_CLK) begin
    if (mem_we) mem[mem_addr] <= (mem[mem_addr] & ~mem_bm) | (mem_din & mem_bm);
  end

  // Registered read, holds when not reading; samples pre-write contents.
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) A_DOUT <= '0;
    else if (mem_re) A_DOUT <= mem[mem_addr];
  end

endmodule

// File: tb/tb_sram_1p_march_bist.sv
// Purpose: directed self-checking bench for sram_1p_march_bist (DATA_WIDTH=32, ADDR_WIDTH=4).
// Latency: checks 1-cycle read data and the 161-cycle self-test window.
// Backpressure: checks that the functional port is blocked while the self-test runs.
module tb_sram_1p_march_bist;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          men, wen, ren, start;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, bm;
  logic [DW-1:0] dout;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          men;
    logic          wen;
    logic          ren;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] bm;
    logic          chk;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  sram_1p_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .A_CLK(clk), .A_RST(rst), .A_MEN(men), .A_WEN(wen), .A_REN(ren),
    .A_ADDR(addr), .A_DIN(din), .A_BM(bm), .A_DOUT(dout),
    .A_BIST_START(start), .A_BIST_BUSY(busy), .A_BIST_DONE(done),
    .A_BIST_FAIL(fail), .A_BIST_FAIL_ADDR(fail_addr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Single functional access: drive, clock once, return to idle.
  task automatic access(input logic w, input logic r, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] m);
    men = 1'b1; wen = w; ren = r; addr = a; din = d; bm = m;
    tick;
    men = 1'b0; wen = 1'b0; ren = 1'b0;
  endtask

`ifdef SRAM_MARCH_BIST_EN
  // Full self-test run. Functional write+read to word 4 is held on throughout, and a
  // second START is pulsed mid-run; both must be ignored.
  task automatic run_bist(output int busy_n, output int fail_at, output logic [DW-1:0] dout2,
                          output logic done1, output logic fail1);
    start = 1'b1;
    tick;
    start = 1'b0;
    men = 1'b1; wen = 1'b1; ren = 1'b1; addr = 4'd4; din = 32'h0000_0005; bm = '1;
    busy_n = 0; fail_at = 0; dout2 = '0; done1 = 1'b1; fail1 = 1'b1;
    while (busy && busy_n < 2000) begin
      busy_n++;
      if (busy_n == 1) begin done1 = done; fail1 = fail; end
      if (busy_n == 2) dout2 = dout;
      if (fail && fail_at == 0) fail_at = busy_n;
      start = (busy_n == 10);
      tick;
    end
    start = 1'b0; men = 1'b0; wen = 1'b0; ren = 1'b0;
  endtask
`endif

  initial begin
    int          busy_n, fail_at;
    logic [DW-1:0] dout2;
    logic        done1, fail1;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'd3, 32'h0,        32'h0,        1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd7, 32'h0,        32'h0000FF00, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'd7, 32'h0,        32'h0,        1'b1, 32'hFFFF00FF};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'd2, 32'h11111111, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'd2, 32'h22222222, 32'hFFFFFFFF, 1'b1, 32'h11111111};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'd2, 32'h0,        32'h0,        1'b1, 32'h22222222};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'd7, 32'h0,        32'hFFFFFFFF, 1'b1, 32'h22222222};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd3, 32'h0,        32'h0,        1'b1, 32'h22222222};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 4'd7, 32'h0,        32'h0,        1'b1, 32'hFFFF00FF};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'd3, 32'h0,        32'h0,        1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 4'd3, 32'h0,        32'h0,        1'b1, 32'hDEADBEEF};

    rst = 1'b1; men = 1'b0; wen = 1'b0; ren = 1'b0; start = 1'b0;
    addr = '0; din = '0; bm = '0;
    tick; tick;
    check("rst_dout", dout, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fail", fail, 1'b0);
    check("rst_fail_addr", fail_addr, 4'd0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 13; i++) begin
      men = vecs[i].men; wen = vecs[i].wen; ren = vecs[i].ren;
      addr = vecs[i].addr; din = vecs[i].din; bm = vecs[i].bm;
      tick;
      if (vecs[i].chk) check($sformatf("vec%0d_dout", i), dout, vecs[i].exp);
    end
    men = 1'b0; wen = 1'b0; ren = 1'b0;

`ifdef SRAM_MARCH_BIST_EN
    // Fault-free run.
    run_bist(busy_n, fail_at, dout2, done1, fail1);
    check("clean_busy_cycles", busy_n, 161);
    check("clean_done_low_while_busy", done1, 1'b0);
    check("clean_dout_held_in_m0", dout2, 32'hDEADBEEF);
    check("clean_done", done, 1'b1);
    check("clean_fail", fail, 1'b0);
    access(1'b0, 1'b1, 4'd4, '0, '0);
    check("post_bist_word4_zero", dout, 32'h0);
    access(1'b1, 1'b0, 4'd4, 32'hA5A5A5A5, 32'hFFFFFFFF);
    access(1'b0, 1'b1, 4'd4, '0, '0);
    check("post_bist_functional", dout, 32'hA5A5A5A5);
    check("done_stays_high", done, 1'b1);

    // Word 5 bit 3 stuck-at-1: first hit is the M1 read of word 5.
    force dut.mem[5][3] = 1'b1;
    run_bist(busy_n, fail_at, dout2, done1, fail1);
    check("f5_done_cleared_by_start", done1, 1'b0);
    check("f5_busy_cycles", busy_n, 161);
    check("f5_fail_first_cycle", fail_at, 29);
    check("f5_fail", fail, 1'b1);
    check("f5_fail_addr", fail_addr, 4'd5);
    check("f5_done", done, 1'b1);

    // Add word 9: the first failure still wins.
    force dut.mem[9][3] = 1'b1;
    run_bist(busy_n, fail_at, dout2, done1, fail1);
    check("f59_fail_cleared_by_start", fail1, 1'b0);
    check("f59_fail", fail, 1'b1);
    check("f59_fail_addr", fail_addr, 4'd5);

    // Only word 9 faulty.
    release dut.mem[5][3];
    run_bist(busy_n, fail_at, dout2, done1, fail1);
    check("f9_fail_first_cycle", fail_at, 37);
    check("f9_fail_addr", fail_addr, 4'd9);
    release dut.mem[9][3];

    // Reset in the middle of a failing run.
    force dut.mem[5][3] = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 1; i < 50; i++) tick;
    check("mid_busy", busy, 1'b1);
    check("mid_fail", fail, 1'b1);
    check("mid_dout_m2_read", dout, 32'hFFFFFFFF);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_fail", fail, 1'b0);
    check("arst_fail_addr", fail_addr, 4'd0);
    check("arst_dout", dout, 32'h0);
    tick;
    rst = 1'b0;
    release dut.mem[5][3];
    tick;
    run_bist(busy_n, fail_at, dout2, done1, fail1);
    check("rerun_busy_cycles", busy_n, 161);
    check("rerun_done", done, 1'b1);
    check("rerun_fail", fail, 1'b0);
`else
    // Self-test not built: START has no effect and the port stays live.
    start = 1'b1;
    tick;
    start = 1'b0;
    check("nobist_busy", busy, 1'b0);
    access(1'b0, 1'b1, 4'd7, '0, '0);
    check("nobist_read", dout, 32'hFFFF00FF);
    check("nobist_done", done, 1'b0);
    check("nobist_fail", fail, 1'b0);
    check("nobist_fail_addr", fail_addr, 4'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
